// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard controller: forwarding select codes,
// memory-wait FSM encoding, default watchdog limit and the forward-select helper.
package hazard_pkg;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

  localparam int MEM_TIMEOUT_DEF = 64;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } memState_t;

  // E-stage operand select. The M-stage result is the younger value, so it wins over W.
  // Register 0 is hardwired to zero and is never forwarded.
  function automatic logic [1:0] fwdSel(input logic [4:0] src,
                                        input logic [4:0] wrM, input logic wenM,
                                        input logic [4:0] wrW, input logic wenW);
    logic [1:0] sel;
    sel = FWD_NONE;
    if (src != 5'd0 && wenM && src == wrM)      sel = FWD_MEM;
    else if (src != 5'd0 && wenW && src == wrW) sel = FWD_WB;
    return sel;
  endfunction

endpackage

// File: rtl/hazard_memwait.sv
// Data-memory wait sequencer: freezes the pipeline while an M-stage access
// waits for dmem_ack, with a watchdog that forces release after MEM_TIMEOUT
// stalled cycles and raises a sticky error flag.
module hazard_memwait
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic memop,
  input  logic dmemAck,
  output logic memstall,
  output logic memErr
);

  memState_t  state, nextState;
  logic [7:0] wcnt, nextWcnt;
  logic       setErr;

  // State, wait counter and sticky error register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      wcnt   <= 8'd0;
      memErr <= 1'b0;
    end else begin
      state <= nextState;
      wcnt  <= nextWcnt;
      if (setErr) memErr <= 1'b1;
    end
  end

  // Next state and stall decode; wcnt equals the number of stall cycles already spent
  always_comb begin
    nextState = state;
    nextWcnt  = wcnt;
    setErr    = 1'b0;
    memstall  = 1'b0;
    unique case (state)
      IDLE: begin
        // A zero-wait access (ack in the request cycle) never leaves IDLE.
        if (memop && !dmemAck) begin
          nextState = WAIT;
          nextWcnt  = 8'd1;
          memstall  = 1'b1;
        end
      end
      WAIT: begin
        if (dmemAck) begin
          nextState = IDLE;
          nextWcnt  = 8'd0;
        end else if (wcnt == 8'(MEM_TIMEOUT)) begin
          nextState = IDLE;
          nextWcnt  = 8'd0;
          setErr    = 1'b1;
        end else begin
          nextWcnt  = wcnt + 8'd1;
          memstall  = 1'b1;
        end
      end
      default: nextState = IDLE;
    endcase
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the five-stage core: forwarding selects,
// load-use / branch stalls, E flush, and the data-memory wait freeze.
// Optional feature macro: HAZARD_PERF_EN adds three stall-cycle counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int CNT_W       = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rsD,
  input  logic [4:0] rtD,
  input  logic [4:0] rsE,
  input  logic [4:0] rtE,
  input  logic [4:0] writeregE,
  input  logic [4:0] writeregM,
  input  logic [4:0] writeregW,
  input  logic       regwriteE,
  input  logic       regwriteM,
  input  logic       regwriteW,
  input  logic       mem2regE,
  input  logic       mem2regM,
  input  logic       memwriteM,
  input  logic       branchD,
  input  logic       dmem_ack,
  output logic       dmem_req,
  output logic       forwardAD,
  output logic       forwardBD,
  output logic [1:0] forwardAE,
  output logic [1:0] forwardBE,
  output logic       stallF,
  output logic       stallD,
  output logic       stallE,
  output logic       stallM,
  output logic       flushE,
  output logic       flushW,
  output logic       mem_err
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] perf_lw,
  output logic [CNT_W-1:0] perf_br,
  output logic [CNT_W-1:0] perf_mem
`endif
);

  localparam int NSRC = 2;  // operand 0 = rs, operand 1 = rt

  if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > 255) begin : gBadTimeout
    $error("hazard_ctrl: MEM_TIMEOUT must be 1..255");
  end
  if (CNT_W < 1) begin : gBadCntW
    $error("hazard_ctrl: CNT_W must be at least 1");
  end

  logic [NSRC-1:0][4:0] srcE, srcD;
  logic [NSRC-1:0][1:0] fwdE;
  logic [NSRC-1:0]      fwdD;
  logic                 lwstall, brstall, memstall, memop;

  assign srcE = {rtE, rsE};
  assign srcD = {rtD, rsD};

  for (genvar g = 0; g < NSRC; g++) begin : gFwd
    assign fwdE[g] = fwdSel(srcE[g], writeregM, regwriteM, writeregW, regwriteW);
    assign fwdD[g] = (srcD[g] != 5'd0) && regwriteM && (srcD[g] == writeregM);
  end

  assign forwardAE = fwdE[0];
  assign forwardBE = fwdE[1];
  assign forwardAD = fwdD[0];
  assign forwardBD = fwdD[1];

  // Load-use: E-stage load feeds a D-stage source. Branch: the D-stage comparator
  // needs a value still in the ALU or a load result still in M.
  assign lwstall = mem2regE && (rtE == rsD || rtE == rtD);
  assign brstall = branchD &&
                   ((regwriteE && (writeregE == rsD || writeregE == rtD)) ||
                    (mem2regM  && (writeregM == rsD || writeregM == rtD)));

  assign memop    = mem2regM | memwriteM;
  assign dmem_req = memop;

  hazard_memwait #(.MEM_TIMEOUT(MEM_TIMEOUT)) uMemWait (
    .clk      (clk),
    .reset    (reset),
    .memop    (memop),
    .dmemAck  (dmem_ack),
    .memstall (memstall),
    .memErr   (mem_err)
  );

  // A memory freeze holds every stage; E is held, not flushed, while it lasts.
  assign stallF = lwstall | brstall | memstall;
  assign stallD = stallF;
  assign stallE = memstall;
  assign stallM = memstall;
  assign flushW = memstall;
  assign flushE = (lwstall | brstall) & ~memstall;

`ifdef HAZARD_PERF_EN
  // Stall-cycle counters; they wrap naturally at 2^CNT_W
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_lw  <= '0;
      perf_br  <= '0;
      perf_mem <= '0;
    end else begin
      if (lwstall && !memstall) perf_lw  <= perf_lw + 1'b1;
      if (brstall && !memstall) perf_br  <= perf_br + 1'b1;
      if (memstall)             perf_mem <= perf_mem + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_hazard_ctrl;
  localparam int TO = 4;
  localparam int CW = 32;

  logic clk = 1'b0, reset = 1'b0;
  logic [4:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
  logic regwriteE, regwriteM, regwriteW, mem2regE, mem2regM, memwriteM, branchD, dmem_ack;
  logic dmem_req, forwardAD, forwardBD, stallF, stallD, stallE, stallM, flushE, flushW, mem_err;
  logic [1:0] forwardAE, forwardBE;
`ifdef HAZARD_PERF_EN
  logic [CW-1:0] perf_lw, perf_br, perf_mem;
  logic [CW-1:0] mPerfLw = '0, mPerfBr = '0, mPerfMem = '0;
`endif

  int tests = 0, fails = 0;
  int mElapsed = 0;   // stall cycles spent on the access in progress (0 = none)
  bit mErr = 1'b0;

  hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
    .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
    .mem2regE(mem2regE), .mem2regM(mem2regM), .memwriteM(memwriteM),
    .branchD(branchD), .dmem_ack(dmem_ack), .dmem_req(dmem_req),
    .forwardAD(forwardAD), .forwardBD(forwardBD),
    .forwardAE(forwardAE), .forwardBE(forwardBE),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
    .flushE(flushE), .flushW(flushW), .mem_err(mem_err)
`ifdef HAZARD_PERF_EN
    , .perf_lw(perf_lw), .perf_br(perf_br), .perf_mem(perf_mem)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---- behavioural model ----
  function automatic logic [1:0] mFwdE(input logic [4:0] src);
    if (src == 0) return 2'd0;
    if (regwriteM && src == writeregM) return 2'd2;
    if (regwriteW && src == writeregW) return 2'd1;
    return 2'd0;
  endfunction

  function automatic bit mFwdD(input logic [4:0] src);
    return src != 0 && regwriteM && src == writeregM;
  endfunction

  function automatic bit mLw();
    return mem2regE && (rtE == rsD || rtE == rtD);
  endfunction

  function automatic bit mBr();
    return branchD && ((regwriteE && (writeregE == rsD || writeregE == rtD)) ||
                       (mem2regM && (writeregM == rsD || writeregM == rtD)));
  endfunction

  // Pipeline is frozen while an access waits: a new access stalls unless
  // acked at once; a waiting access stalls until ack or until TO cycles are spent.
  function automatic bit mMemStall();
    if (mElapsed > 0) return !dmem_ack && mElapsed < TO;
    return (mem2regM || memwriteM) && !dmem_ack;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mElapsed <= 0;
      mErr     <= 1'b0;
`ifdef HAZARD_PERF_EN
      mPerfLw <= '0; mPerfBr <= '0; mPerfMem <= '0;
`endif
    end else begin
      if (mMemStall()) mElapsed <= mElapsed + 1;
      else begin
        if (mElapsed == TO && !dmem_ack) mErr <= 1'b1;
        mElapsed <= 0;
      end
`ifdef HAZARD_PERF_EN
      if (mLw() && !mMemStall()) mPerfLw <= mPerfLw + 1'b1;
      if (mBr() && !mMemStall()) mPerfBr <= mPerfBr + 1'b1;
      if (mMemStall())           mPerfMem <= mPerfMem + 1'b1;
`endif
    end
  end

  // Compare every cycle on the falling edge
  always @(negedge clk) begin
    bit ms, hz;
    ms = mMemStall();
    hz = mLw() || mBr();
    chk("forwardAE", forwardAE, mFwdE(rsE));
    chk("forwardBE", forwardBE, mFwdE(rtE));
    chk("forwardAD", forwardAD, mFwdD(rsD));
    chk("forwardBD", forwardBD, mFwdD(rtD));
    chk("dmem_req", dmem_req, mem2regM || memwriteM);
    chk("stallF", stallF, hz || ms);
    chk("stallD", stallD, hz || ms);
    chk("stallE", stallE, ms);
    chk("stallM", stallM, ms);
    chk("flushW", flushW, ms);
    chk("flushE", flushE, hz && !ms);
    chk("mem_err", mem_err, mErr);
`ifdef HAZARD_PERF_EN
    chk("perf_lw", perf_lw, mPerfLw);
    chk("perf_br", perf_br, mPerfBr);
    chk("perf_mem", perf_mem, mPerfMem);
`endif
  end

  // ---- stimulus ----
  task automatic clearIn();
    rsD = 0; rtD = 0; rsE = 0; rtE = 0;
    writeregE = 0; writeregM = 0; writeregW = 0;
    regwriteE = 0; regwriteM = 0; regwriteW = 0;
    mem2regE = 0; mem2regM = 0; memwriteM = 0; branchD = 0; dmem_ack = 0;
  endtask

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  initial begin
    clearIn();
    #1 reset = 1'b1;
    @(negedge clk);
    chk("rst_mem_err", mem_err, 0);
    chk("rst_stallE", stallE, 0);
    chk("rst_dmem_req", dmem_req, 0);
    nxt(); reset = 1'b0;

    // forwarding, M priority over W
    writeregM = 5; regwriteM = 1; writeregW = 5; regwriteW = 1; rsE = 5;
    @(negedge clk); chk("fwd_mem", forwardAE, 2'b10);
    nxt(); rsE = 0;
    @(negedge clk); chk("fwd_r0", forwardAE, 2'b00);
    nxt(); regwriteM = 0; rtE = 5;
    @(negedge clk); chk("fwd_wb", forwardBE, 2'b01);

    // load-use stall
    nxt(); clearIn(); mem2regE = 1; rtE = 8; rsD = 8;
    @(negedge clk);
    chk("lw_stallF", stallF, 1); chk("lw_stallD", stallD, 1); chk("lw_flushE", flushE, 1);
    nxt(); mem2regE = 0;
    @(negedge clk);
    chk("lw_clr_stallF", stallF, 0); chk("lw_clr_flushE", flushE, 0);

    // branch stall, then forward from M
    nxt(); clearIn(); branchD = 1; regwriteE = 1; writeregE = 3; rtD = 3;
    @(negedge clk);
    chk("br_stallD", stallD, 1); chk("br_flushE", flushE, 1);
    nxt(); regwriteE = 0; writeregE = 0; regwriteM = 1; writeregM = 3;
    @(negedge clk);
    chk("br_fwdBD", forwardBD, 1); chk("br_nostall", stallD, 0);

    // load waits 3 cycles for ack, with a load-use hazard pending
    nxt(); clearIn(); mem2regM = 1; writeregM = 9; mem2regE = 1; rtE = 8; rsD = 8;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mw_stallE", stallE, 1); chk("mw_stallM", stallM, 1);
      chk("mw_flushW", flushW, 1); chk("mw_flushE", flushE, 0);
      nxt();
    end
    dmem_ack = 1;
    @(negedge clk); chk("mw_release", stallE, 0);
    nxt(); clearIn();
`ifdef HAZARD_PERF_EN
    @(negedge clk); chk("mw_perf_mem", perf_mem, 3);
    nxt();
`endif

    // zero-wait access
    clearIn(); mem2regM = 1; dmem_ack = 1;
    @(negedge clk); chk("zw_nostall", stallE, 0);
    nxt(); clearIn();
    @(negedge clk); chk("zw_idle", stallE, 0);

    // store times out
    nxt(); memwriteM = 1;
    for (int i = 0; i < TO; i++) begin
      @(negedge clk); chk("to_stall", stallE, 1);
      nxt();
    end
    @(negedge clk); chk("to_release", stallE, 0); chk("to_err_pre", mem_err, 0);
    nxt(); memwriteM = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk("to_err_sticky", mem_err, 1);
      nxt();
    end

    // reset mid-wait aborts it
    reset = 1;
    @(negedge clk); chk("rst2_err", mem_err, 0);
    nxt(); reset = 0; memwriteM = 1;
    @(negedge clk); chk("rw_stall0", stallE, 1);
    nxt();
    @(negedge clk); chk("rw_stall1", stallE, 1);
    nxt(); reset = 1; memwriteM = 0;
    @(negedge clk); chk("rw_abort", stallE, 0); chk("rw_err", mem_err, 0);
    nxt(); reset = 0;
    @(negedge clk); chk("rw_idle", stallE, 0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      nxt();
      rsD = 5'($urandom_range(0, 3)); rtD = 5'($urandom_range(0, 3));
      rsE = 5'($urandom_range(0, 3)); rtE = 5'($urandom_range(0, 3));
      writeregE = 5'($urandom_range(0, 3)); writeregM = 5'($urandom_range(0, 3));
      writeregW = 5'($urandom_range(0, 3));
      regwriteE = 1'($urandom); regwriteM = 1'($urandom); regwriteW = 1'($urandom);
      mem2regE = ($urandom_range(0, 3) == 0);
      mem2regM = ($urandom_range(0, 3) == 0);
      memwriteM = ($urandom_range(0, 4) == 0);
      branchD = ($urandom_range(0, 2) == 0);
      dmem_ack = ($urandom_range(0, 5) == 0);
      reset = ($urandom_range(0, 299) == 0);
    end
    nxt(); reset = 0;
    @(negedge clk);
    nxt();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
